// File: rtl/barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Purpose:
//   Parametrised barrel shifter with valid/ready streaming on both sides.
//   The shift amount is applied as log2(WIDTH) levels of 1, 2, 4, ...
//   Supported operations: logical left, logical right, arithmetic right,
//   rotate left and rotate right. Besides the result it returns the last bit
//   shifted/rotated across the word boundary (carry) and a zero flag.
//
//   PIPELINED = 1 : one register slot after every level, latency SW cycles,
//                   one beat per cycle throughput.
//   PIPELINED = 0 : all levels combinational into a single output slot,
//                   latency 1 cycle.
//
// Ports:
//   i_clk        in   1      clock, rising edge
//   i_rst_n      in   1      asynchronous active-low reset
//   i_in_valid   in   1      input beat present
//   o_in_ready   out  1      beat accepted this cycle when i_in_valid is high
//   i_din        in   WIDTH  operand
//   i_shamt      in   SW     shift amount 0..WIDTH-1
//   i_lr         in   1      1 = left, 0 = right
//   i_al         in   1      1 = arithmetic (right shift only)
//   i_rot        in   1      1 = rotate (overrides i_al)
//   o_out_valid  out  1      result beat present
//   i_out_ready  in   1      downstream accepts the result beat
//   o_dout       out  WIDTH  shifted/rotated result
//   o_carry      out  1      last bit moved across the boundary, 0 for shamt=0
//   o_zero       out  1      o_dout == 0
// ---------------------------------------------------------------------------
module barrel_shifter_pipe #(
    parameter int  WIDTH     = 32,
    parameter int  PIPELINED = 1,
    localparam int SW        = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_din,
    input  logic [SW-1:0]    i_shamt,
    input  logic             i_lr,
    input  logic             i_al,
    input  logic             i_rot,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_carry,
    output logic             o_zero
);

    // Number of register slots; the last slot is the output register.
    localparam int NS = (PIPELINED != 0) ? SW : 1;

    // Everything a beat needs to finish its remaining levels travels with it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    shamt;
        logic             lr;
        logic             rot;
        logic             fill;   // sign bit for arithmetic right, else 0
        logic             carry;
    } beat_t;

    // One shift level of 2^k positions, applied only when shamt[k] is set.
    // The carry picks the last bit that crosses the boundary at this level;
    // for rotates that bit equals dout[0] (left) or dout[WIDTH-1] (right)
    // once all levels are done, so shifts and rotates share the same index.
    function automatic beat_t apply_level(input beat_t b, input int k);
        beat_t           r;
        int              s;
        logic [SW-1:0]   idx;
        r   = b;
        s   = 1 << k;
        idx = '0;
        if (|(b.shamt & (SW'(1) << k))) begin
            if (b.lr) begin
                r.data = b.data << s;
                if (b.rot) begin
                    r.data = r.data | (b.data >> (WIDTH - s));
                end
                idx     = SW'(WIDTH - s);
                r.carry = b.data[idx];
            end else begin
                r.data = b.data >> s;
                if (b.rot) begin
                    r.data = r.data | (b.data << (WIDTH - s));
                end else if (b.fill) begin
                    r.data = r.data | ~({WIDTH{1'b1}} >> s);
                end
                idx     = SW'(s - 1);
                r.carry = b.data[idx];
            end
        end
        return r;
    endfunction

    beat_t w_in_beat;
    beat_t w_stage_out [NS];
    beat_t r_slot      [NS];
    logic  r_valid     [NS];
    logic  w_src_valid [NS];
    logic  w_ready     [NS+1];
    logic  r_zero;

    // Capture the sign at the input so arithmetic fill does not depend on
    // partially shifted data further down the pipe.
    always_comb begin
        w_in_beat.data  = i_din;
        w_in_beat.shamt = i_shamt;
        w_in_beat.lr    = i_lr;
        w_in_beat.rot   = i_rot;
        w_in_beat.fill  = i_al & ~i_lr & ~i_rot & i_din[WIDTH-1];
        w_in_beat.carry = 1'b0;
    end

    assign w_ready[NS] = i_out_ready;

    generate
        if (PIPELINED != 0) begin : g_pipe
            for (genvar gi = 0; gi < NS; gi++) begin : g_lvl
                if (gi == 0) begin : g_first
                    assign w_stage_out[gi] = apply_level(w_in_beat, gi);
                end else begin : g_next
                    assign w_stage_out[gi] = apply_level(r_slot[gi-1], gi);
                end
            end
        end else begin : g_comb
            always_comb begin
                beat_t b;
                b = w_in_beat;
                for (int k = 0; k < SW; k++) begin
                    b = apply_level(b, k);
                end
                w_stage_out[0] = b;
            end
        end
    endgenerate

    // Slot k advances when it is empty or the slot after it advances, so
    // bubbles collapse and the chain of readies reaches o_in_ready.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slot
            if (gi == 0) begin : g_src_in
                assign w_src_valid[gi] = i_in_valid;
            end else begin : g_src_slot
                assign w_src_valid[gi] = r_valid[gi-1];
            end

            assign w_ready[gi] = !r_valid[gi] || w_ready[gi+1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_valid[gi] <= 1'b0;
                    r_slot[gi]  <= '0;
                end else if (w_ready[gi]) begin
                    r_valid[gi] <= w_src_valid[gi];
                    // Payload only loads with a real beat, so idle inputs
                    // never disturb held data.
                    if (w_src_valid[gi]) begin
                        r_slot[gi] <= w_stage_out[gi];
                    end
                end
            end
        end
    endgenerate

    // Zero flag is registered alongside the output slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero <= 1'b0;
        end else if (w_ready[NS-1] && w_src_valid[NS-1]) begin
            r_zero <= (w_stage_out[NS-1].data == '0);
        end
    end

    assign o_in_ready  = w_ready[0];
    assign o_out_valid = r_valid[NS-1];
    assign o_dout      = r_slot[NS-1].data;
    assign o_carry     = r_slot[NS-1].carry;
    assign o_zero      = r_zero;

    // Control fields of the output slot are not needed past the last level.
    logic w_unused;
    assign w_unused = ^{r_slot[NS-1].shamt, r_slot[NS-1].lr,
                        r_slot[NS-1].rot, r_slot[NS-1].fill};

endmodule
